// File: rtl/instr_loader.sv
// Byte-stream program loader: parses a length/payload/XOR-checksum frame, writes
// little-endian instruction words to consecutive word addresses and gates CPU reset.
module instr_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        StIdle, StLen0, StLen1, StData, StCsum, StDone, StErr
    } state_t;

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  csum;
    logic [15:0] len_full;
    logic        accept;

    assign len_full = {byte_data, len_lo};
    assign accept   = byte_valid && byte_ready;

    always_comb begin
        byte_ready = 1'b0;
        case (state)
            StLen0, StLen1, StData, StCsum: byte_ready = 1'b1;
            default:                        byte_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            len_lo   <= 8'd0;
            n_words  <= 16'd0;
            word_idx <= 16'd0;
            byte_idx <= 2'd0;
            word_buf <= 24'd0;
            csum     <= 8'd0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state    <= StLen0;
                        word_idx <= 16'd0;
                        byte_idx <= 2'd0;
                        csum     <= 8'd0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                StLen0: begin
                    if (accept) begin
                        len_lo <= byte_data;
                        state  <= StLen1;
                    end
                end
                StLen1: begin
                    if (accept) begin
                        n_words <= len_full;
                        if (32'(len_full) > MEM_SIZE) begin
                            state <= StErr;
                            error <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= StCsum;
                        end else begin
                            state <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        csum <= csum ^ byte_data;
                        if (byte_idx == 2'd3) begin
                            // word_buf already holds bytes 0..2, LSB first
                            wr_en    <= 1'b1;
                            wr_addr  <= ADDR_WIDTH'({word_idx, 2'b00});
                            wr_data  <= DATA_WIDTH'({byte_data, word_buf});
                            word_idx <= word_idx + 16'd1;
                            byte_idx <= 2'd0;
                            if (word_idx == n_words - 16'd1) begin
                                state <= StCsum;
                            end
                        end else begin
                            word_buf <= {byte_data, word_buf[23:8]};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                StCsum: begin
                    if (accept) begin
                        if (byte_data == csum) begin
                            state    <= StDone;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= StErr;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a frame-level model queues expected writes and
// end-of-load status; a negedge monitor pops and compares as the DUT produces them.
module tb_instr_loader;

    localparam int unsigned MEM_SIZE = 512;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    wr_t         exp_wr[$];
    logic [2:0]  exp_st[$];   // {done, error, cpu_hold}
    logic [7:0]  frame[$];
    logic [31:0] wq[$];
    logic        done_q = 1'b0;
    logic        err_q  = 1'b0;

    instr_loader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_SIZE  (MEM_SIZE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every wr_en cycle and every rising done/error is compared against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", {wr_addr, wr_data}, 64'd0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(w.addr));
                    check("wr_data", 64'(wr_data), 64'(w.data));
                end
            end
            if ((done && !done_q) || (error && !err_q)) begin
                check("writes_before_status", 64'(exp_wr.size()), 64'd0);
                if (exp_st.size() == 0) check("unexpected_status", {61'd0, done, error, cpu_hold}, 64'd0);
                else check("status", {61'd0, done, error, cpu_hold}, {61'd0, exp_st.pop_front()});
            end
            done_q <= done;
            err_q  <= error;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int cnt;
        @(negedge clk);
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        cnt = 0;
        while (!byte_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!byte_ready) check("byte_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
    endtask

    task automatic make_frame(input int n, input logic [7:0] flip);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'd0;
        frame.delete();
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = wq[i][8*k +: 8];
                frame.push_back(b);
                x ^= b;
            end
        end
        frame.push_back(x ^ flip);
    endtask

    // Reference model works on the whole frame: decides writes, outcome and bytes consumed.
    task automatic run_frame(input int gap_pct);
        int n;
        int nsend;
        logic [7:0] x;
        wr_t w;
        n = int'(frame[0]) | (int'(frame[1]) << 8);
        if (n > int'(MEM_SIZE)) begin
            exp_st.push_back(3'b011);
            nsend = 2;
        end else begin
            x = 8'd0;
            for (int i = 0; i < n; i++) begin
                w.addr = 32'(i * 4);
                w.data = {frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]};
                exp_wr.push_back(w);
                for (int k = 0; k < 4; k++) x ^= frame[2+4*i+k];
            end
            exp_st.push_back(frame[2+4*n] == x ? 3'b100 : 3'b011);
            nsend = 2 + 4 * n + 1;
        end
        pulse_start();
        for (int i = 0; i < nsend; i++) send_byte(frame[i], gap_pct);
        @(negedge clk) byte_valid = 1'b0;
        for (int i = 0; i < 5 && exp_st.size() != 0; i++) @(negedge clk);
        if (exp_st.size() != 0) begin
            check("status_timeout", 64'(exp_st.size()), 64'd0);
            exp_st.delete();
            exp_wr.delete();
        end
    endtask

    task automatic two_word_frame(input logic [7:0] flip);
        wq.delete();
        wq.push_back(32'h0000_0013);
        wq.push_back(32'h0010_0093);
        make_frame(2, flip);   // payload XOR is 0x90
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        check("rst_done_error", {62'd0, done, error}, 64'd0);
        check("rst_byte_ready", 64'(byte_ready), 64'd0);
        reset = 1'b1;

        two_word_frame(8'h00);
        run_frame(0);

        frame = {8'h00, 8'h00, 8'h00};
        run_frame(0);

        frame = {8'h01, 8'h02};
        run_frame(0);
        check("oversize_byte_ready", 64'(byte_ready), 64'd0);
        check("oversize_cpu_hold", 64'(cpu_hold), 64'd1);

        two_word_frame(8'h00);
        run_frame(0);

        two_word_frame(8'h11);   // checksum byte 0x81
        run_frame(0);
        check("mismatch_done", 64'(done), 64'd0);

        two_word_frame(8'h00);
        run_frame(50);

        // Bytes offered in DONE are ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            check("done_byte_ready", 64'(byte_ready), 64'd0);
        end
        @(negedge clk) byte_valid = 1'b0;
        check("done_hold", {62'd0, done, cpu_hold}, 64'd2);

        // Reset mid-load, after the 2nd data byte
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_outputs", {wr_en, cpu_hold, done, error, byte_ready}, 64'b01000);
        check("midrst_addr_data", {wr_addr, wr_data}, 64'd0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_idle", {62'd0, byte_ready, wr_en}, 64'd0);
        wq.delete();
        wq.push_back(32'hDEAD_BEEF);
        wq.push_back(32'h0123_4567);
        wq.push_back(32'h89AB_CDEF);
        make_frame(3, 8'h00);
        run_frame(0);

        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(6);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            make_frame(n, ($urandom_range(2) == 0) ? 8'($urandom_range(255, 1)) : 8'h00);
            run_frame($urandom_range(60));
        end

        // Full-capacity image reaches the top address 0x7FC
        wq.delete();
        for (int i = 0; i < int'(MEM_SIZE); i++) wq.push_back($urandom);
        make_frame(int'(MEM_SIZE), 8'h00);
        run_frame(0);

        frame = {8'h01, 8'h02};
        run_frame(20);

        check("leftover_writes", 64'(exp_wr.size()), 64'd0);
        check("leftover_status", 64'(exp_st.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
